// File: rtl/sample_decimator.sv
// Multi-channel audio decimator: power-of-two window, pick-last or floor-average,
// one output register stage with hold-until-accepted and overrun flagging.

module sample_decimator_lane #(
  parameter int DATA_SIZE = 24,
  parameter int MAX_LOG2  = 4,
  parameter int LW        = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 first,
  input  logic                 avg,
  input  logic [LW-1:0]        shift,
  input  logic [DATA_SIZE-1:0] sample,
  output logic [DATA_SIZE-1:0] result
);
  localparam int AW = DATA_SIZE + MAX_LOG2;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;

  // First frame of a window loads rather than adds, so no separate clear is needed.
  assign sum    = (first ? '0 : acc) + {{MAX_LOG2{sample[DATA_SIZE-1]}}, sample};
  assign result = avg ? DATA_SIZE'(sum >>> shift) : sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc <= '0;
    else if (load) acc <= sum;
  end
endmodule

module sample_decimator #(
  parameter int DATA_SIZE = 24,
  parameter int CHANNELS  = 2,
  parameter int MAX_LOG2  = 4,
  parameter int LW        = $clog2(MAX_LOG2 + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [CHANNELS*DATA_SIZE-1:0] audio_data_in,
  input  logic [LW-1:0]                 factor_log2,
  input  logic                          avg_mode,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [CHANNELS*DATA_SIZE-1:0] audio_data_out,
  output logic                          overrun
);
  localparam int CW = MAX_LOG2;

  logic [CW-1:0]                          cnt;
  logic [CW-1:0]                          last_idx;
  logic [LW-1:0]                          req_log2, lat_log2, eff_log2;
  logic                                   lat_avg, eff_avg;
  logic                                   first, produce;
  logic [CHANNELS-1:0][DATA_SIZE-1:0]     frame_in, lane_res, out_data;

  assign frame_in = audio_data_in;
  assign req_log2 = (factor_log2 > LW'(MAX_LOG2)) ? LW'(MAX_LOG2) : factor_log2;
  assign first    = (cnt == '0);

  // The frame that opens a window already runs with the newly requested settings.
  assign eff_log2 = first ? req_log2 : lat_log2;
  assign eff_avg  = first ? avg_mode : lat_avg;
  assign last_idx = (CW'(1) << eff_log2) - CW'(1);
  assign produce  = in_valid && (cnt == last_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      lat_log2 <= '0;
      lat_avg  <= 1'b0;
    end else if (in_valid) begin
      cnt <= produce ? '0 : cnt + CW'(1);
      if (first) begin
        lat_log2 <= req_log2;
        lat_avg  <= avg_mode;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    sample_decimator_lane #(
      .DATA_SIZE(DATA_SIZE),
      .MAX_LOG2 (MAX_LOG2),
      .LW       (LW)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (in_valid),
      .first (first),
      .avg   (eff_avg),
      .shift (eff_log2),
      .sample(frame_in[k]),
      .result(lane_res[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= produce && out_valid && !out_ready;
      if (produce) begin
        out_valid <= 1'b1;
        out_data  <= lane_res;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign audio_data_out = out_data;
endmodule

// File: tb/tb_sample_decimator.sv
// Directed bench for sample_decimator: hand-computed vectors checked by immediate assertions.

module tb_sample_decimator;
  localparam int DS = 24;
  localparam int CH = 2;
  localparam int ML = 4;
  localparam int LW = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [CH*DS-1:0] audio_data_in = '0;
  logic [LW-1:0]    factor_log2 = '0;
  logic             avg_mode = 1'b0;
  logic             out_ready = 1'b1;
  logic             out_valid;
  logic [CH*DS-1:0] audio_data_out;
  logic             overrun;

  int n_asrt = 0;
  int n_fail = 0;

  sample_decimator #(.DATA_SIZE(DS), .CHANNELS(CH), .MAX_LOG2(ML)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .audio_data_in (audio_data_in),
    .factor_log2   (factor_log2),
    .avg_mode      (avg_mode),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .audio_data_out(audio_data_out),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [CH*DS-1:0] fr(input logic [DS-1:0] c0, input logic [DS-1:0] c1);
    return {c1, c0};
  endfunction

  task automatic chk(input string tag, input logic [CH*DS-1:0] obs, input logic [CH*DS-1:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic o, input logic [CH*DS-1:0] d);
    chk({tag, "_valid"}, {47'd0, out_valid}, {47'd0, v});
    chk({tag, "_overrun"}, {47'd0, overrun}, {47'd0, o});
    chk({tag, "_data"}, audio_data_out, d);
  endtask

  // Presents one frame for exactly one rising edge; returns on the following falling edge.
  task automatic send(input logic [CH*DS-1:0] f);
    @(negedge clk);
    in_valid      = 1'b1;
    audio_data_in = f;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [CH*DS-1:0] held;

    // Reset state
    #2;
    chk_out("reset", 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Pick mode, F=4: only the 4th frame appears, one cycle after it
    factor_log2 = 3'd2; avg_mode = 1'b0; out_ready = 1'b1;
    send(fr(24'd1, 24'd10));
    send(fr(24'd2, 24'd20));
    send(fr(24'd3, 24'd30));
    chk_out("pick_mid", 1'b0, 1'b0, '0);
    send(fr(24'd4, 24'd40));
    chk_out("pick_out", 1'b1, 1'b0, fr(24'd4, 24'd40));
    @(negedge clk);
    chk({"pick_accept"}, {47'd0, out_valid}, 48'd0);

    // Average mode, F=4: floor toward -inf and full-scale positive
    avg_mode = 1'b1;
    send(fr(24'hFFFFFF, 24'h7FFFFF));
    send(fr(24'hFFFFFE, 24'h7FFFFF));
    send(fr(24'hFFFFFE, 24'h7FFFFF));
    send(fr(24'hFFFFFE, 24'h7FFFFF));
    chk_out("avg_out", 1'b1, 1'b0, fr(24'hFFFFFE, 24'h7FFFFF));
    @(negedge clk);

    // F=1 pass-through in both modes
    factor_log2 = 3'd0; avg_mode = 1'b0;
    send(fr(24'd5, 24'd6));
    chk_out("f1_pick", 1'b1, 1'b0, fr(24'd5, 24'd6));
    avg_mode = 1'b1;
    send(fr(24'hFFFFFD, 24'd9));
    chk_out("f1_avg", 1'b1, 1'b0, fr(24'hFFFFFD, 24'd9));
    // Back-to-back frames with accept in the same cycle as a new result
    @(negedge clk);
    in_valid = 1'b1; audio_data_in = fr(24'h123456, 24'h654321);
    @(negedge clk);
    audio_data_in = fr(24'h800000, 24'h000001);
    chk_out("b2b_a", 1'b1, 1'b0, fr(24'h123456, 24'h654321));
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("b2b_b", 1'b1, 1'b0, fr(24'h800000, 24'h000001));
    @(negedge clk);

    // Overrun: F=2, no downstream acceptance over two windows
    factor_log2 = 3'd1; avg_mode = 1'b0; out_ready = 1'b0;
    send(fr(24'd11, 24'd12));
    send(fr(24'd13, 24'd14));
    chk_out("ovr_first", 1'b1, 1'b0, fr(24'd13, 24'd14));
    send(fr(24'd15, 24'd16));
    chk_out("ovr_midwin", 1'b1, 1'b0, fr(24'd13, 24'd14));
    send(fr(24'd17, 24'd18));
    chk_out("ovr_pulse", 1'b1, 1'b1, fr(24'd17, 24'd18));
    @(negedge clk);
    chk_out("ovr_drop", 1'b1, 1'b0, fr(24'd17, 24'd18));
    out_ready = 1'b1;
    @(negedge clk);
    chk({"ovr_accept"}, {47'd0, out_valid}, 48'd0);

    // Exponent change mid-window: this window closes at 4, the next at 8
    factor_log2 = 3'd2;
    send(fr(24'd21, 24'd0));
    send(fr(24'd22, 24'd0));
    factor_log2 = 3'd3;
    send(fr(24'd23, 24'd0));
    send(fr(24'd24, 24'd0));
    chk_out("chg_w4", 1'b1, 1'b0, fr(24'd24, 24'd0));
    for (int i = 1; i <= 7; i++) send(fr(24'(100 + i), 24'd0));
    chk({"chg_w8_mid"}, {47'd0, out_valid}, 48'd0);
    send(fr(24'd108, 24'd0));
    chk_out("chg_w8", 1'b1, 1'b0, fr(24'd108, 24'd0));
    @(negedge clk);

    // Exponent above MAX_LOG2 clamps to 16 frames; averages 1..16 and -1..-16
    factor_log2 = 3'd7; avg_mode = 1'b1;
    for (int i = 1; i <= 15; i++) send(fr(24'(i), -24'(i)));
    chk({"clamp_mid"}, {47'd0, out_valid}, 48'd0);
    send(fr(24'd16, -24'd16));
    chk_out("clamp_out", 1'b1, 1'b0, fr(24'd8, 24'hFFFFF7));
    @(negedge clk);

    // Reset mid-window clears everything; a fresh 4-frame window follows
    factor_log2 = 3'd0; avg_mode = 1'b0; out_ready = 1'b0;
    held = fr(24'hABCDEF, 24'h0F0F0F);
    send(held);
    factor_log2 = 3'd2;
    send(fr(24'd31, 24'd0));
    send(fr(24'd32, 24'd0));
    send(fr(24'd33, 24'd0));
    chk_out("rst_pre", 1'b1, 1'b0, held);
    #2 rst_n = 1'b0;
    #1 chk_out("rst_async", 1'b0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    send(fr(24'd41, 24'd1));
    send(fr(24'd42, 24'd2));
    send(fr(24'd43, 24'd3));
    chk({"rst_partial"}, {47'd0, out_valid}, 48'd0);
    send(fr(24'd44, 24'd4));
    chk_out("rst_new", 1'b1, 1'b0, fr(24'd44, 24'd4));

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
